// File: rtl/activate.sv
// Clipped-ReLU activation with a two-way fork: state vector and derivative mask.
// Each output owns a one-entry slot so the two consumers drain independently.
module activate #(
  parameter int    NP    = 3,
  parameter int    NC    = 2,
  parameter int    WF    = 8,
  parameter string BURST = "yes",
  localparam int   WA    = $clog2(NP) + WF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM_Accum0,
  output logic             oReady_AM_Accum0,
  input  logic [NC*WA-1:0] iData_AM_Accum0,
  output logic             oValid_BM_State1,
  input  logic             iReady_BM_State1,
  output logic [NC*WF-1:0] oData_BM_State1,
  output logic             oValid_BM_Mask,
  input  logic             iReady_BM_Mask,
  output logic [NC-1:0]    oData_BM_Mask
);

  localparam bit BURST_EN = (BURST == "yes");

  localparam logic signed [WA-1:0] MAX_A =
    {{(WA-WF+1){1'b0}}, {(WF-1){1'b1}}};
  localparam logic [WF-1:0] MAX_F =
    {1'b0, {(WF-1){1'b1}}};

  logic [NC*WF-1:0] act_st;
  logic [NC-1:0]    act_mk;

  for (genvar k = 0; k < NC; k++) begin : g_lane
    logic signed [WA-1:0] x;
    logic                 neg;
    logic                 sat;
    assign x   = iData_AM_Accum0[k*WA+:WA];
    assign neg = x[WA-1] || (x == '0);
    assign sat = !neg && (x > MAX_A);
    assign act_st[k*WF+:WF] = neg ? '0
                            : sat ? MAX_F
                            : x[WF-1:0];
    assign act_mk[k] = !neg && !sat;
  end

  logic             full_s_q, full_s_d;
  logic             full_m_q, full_m_d;
  logic [NC*WF-1:0] st_q, st_d;
  logic [NC-1:0]    mk_q, mk_d;
  logic             free_s, free_m;
  logic             accept;

  // Burst mode lets a draining slot count as free in the same cycle.
  always_comb begin
    free_s = !full_s_q;
    free_m = !full_m_q;
    if (BURST_EN) begin
      free_s = !full_s_q || iReady_BM_State1;
      free_m = !full_m_q || iReady_BM_Mask;
    end
  end

  assign oReady_AM_Accum0 = !iRST && free_s && free_m;
  assign accept = iValid_AM_Accum0 && oReady_AM_Accum0;

  always_comb begin
    full_s_d = full_s_q;
    full_m_d = full_m_q;
    st_d     = st_q;
    mk_d     = mk_q;
    if (accept) begin
      full_s_d = 1'b1;
      full_m_d = 1'b1;
      st_d     = act_st;
      mk_d     = act_mk;
    end else begin
      if (full_s_q && iReady_BM_State1)
        full_s_d = 1'b0;
      if (full_m_q && iReady_BM_Mask)
        full_m_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      full_s_q <= 1'b0;
      full_m_q <= 1'b0;
      st_q     <= '0;
      mk_q     <= '0;
    end else begin
      full_s_q <= full_s_d;
      full_m_q <= full_m_d;
      st_q     <= st_d;
      mk_q     <= mk_d;
    end
  end

  assign oValid_BM_State1 = full_s_q;
  assign oData_BM_State1  = st_q;
  assign oValid_BM_Mask   = full_m_q;
  assign oData_BM_Mask    = mk_q;

endmodule

// File: tb/tb_activate.sv
// Directed bench for activate: instance 0 is BURST="no", instance 1 is BURST="yes".
module tb_activate;

  logic        iCLK;
  logic        iRST;
  logic        vld [2];
  logic        rdy [2];
  logic [19:0] din [2];
  logic        sv  [2];
  logic        srdy[2];
  logic [15:0] sd  [2];
  logic        mv  [2];
  logic        mrdy[2];
  logic [1:0]  md  [2];

  int nvec = 0;
  int nerr = 0;

  activate #(.NP(3), .NC(2), .WF(8), .BURST("no")) u_no (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iValid_AM_Accum0 (vld[0]),
    .oReady_AM_Accum0 (rdy[0]),
    .iData_AM_Accum0  (din[0]),
    .oValid_BM_State1 (sv[0]),
    .iReady_BM_State1 (srdy[0]),
    .oData_BM_State1  (sd[0]),
    .oValid_BM_Mask   (mv[0]),
    .iReady_BM_Mask   (mrdy[0]),
    .oData_BM_Mask    (md[0])
  );

  activate #(.NP(3), .NC(2), .WF(8), .BURST("yes")) u_yes (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iValid_AM_Accum0 (vld[1]),
    .oReady_AM_Accum0 (rdy[1]),
    .iData_AM_Accum0  (din[1]),
    .oValid_BM_State1 (sv[1]),
    .iReady_BM_State1 (srdy[1]),
    .oData_BM_State1  (sd[1]),
    .oValid_BM_Mask   (mv[1]),
    .iReady_BM_Mask   (mrdy[1]),
    .oData_BM_Mask    (md[1])
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input int a1, input int a0);
    logic [9:0] h;
    logic [9:0] l;
    h = a1[9:0];
    l = a0[9:0];
    return {h, l};
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drain_test(input int i);
    vld[i] = 1'b1;
    din[i] = pk(300, -5);
    srdy[i] = 1'b0;
    mrdy[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
    #1;
    chk($sformatf("dr%0d_sv", i), 32'(sv[i]), 1);
    chk($sformatf("dr%0d_sd", i), 32'(sd[i]), 32'h7F00);
    chk($sformatf("dr%0d_mv", i), 32'(mv[i]), 1);
    chk($sformatf("dr%0d_rdy", i), 32'(rdy[i]), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("dr%0d_hold_sv", i), 32'(sv[i]), 1);
      chk($sformatf("dr%0d_hold_sd", i), 32'(sd[i]), 32'h7F00);
      chk($sformatf("dr%0d_hold_mv", i), 32'(mv[i]), 0);
      chk($sformatf("dr%0d_hold_rdy", i), 32'(rdy[i]), 0);
    end
    srdy[i] = 1'b1;
    #1;
    chk($sformatf("dr%0d_rdy_rise", i), 32'(rdy[i]), (i == 1) ? 1 : 0);
    tick();
    chk($sformatf("dr%0d_sv_done", i), 32'(sv[i]), 0);
    chk($sformatf("dr%0d_rdy_after", i), 32'(rdy[i]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      din[i] = '0;
      srdy[i] = 1'b0;
      mrdy[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_rdy", i), 32'(rdy[i]), 0);
      chk($sformatf("rst%0d_sv", i), 32'(sv[i]), 0);
      chk($sformatf("rst%0d_mv", i), 32'(mv[i]), 0);
    end
    #10;
    iRST = 1'b0;
    #1;
    chk("rel0_rdy", 32'(rdy[0]), 1);
    chk("rel1_rdy", 32'(rdy[1]), 1);

    vld[0] = 1'b1;
    din[0] = pk(100, 1);
    srdy[0] = 1'b1;
    mrdy[0] = 1'b1;
    #1;
    chk("basic_rdy_pre", 32'(rdy[0]), 1);
    tick();
    vld[0] = 1'b0;
    #1;
    chk("basic_sv", 32'(sv[0]), 1);
    chk("basic_sd", 32'(sd[0]), 32'h6401);
    chk("basic_mv", 32'(mv[0]), 1);
    chk("basic_md", 32'(md[0]), 3);
    chk("basic_rdy_full", 32'(rdy[0]), 0);
    tick();
    chk("basic_sv_drop", 32'(sv[0]), 0);
    chk("basic_mv_drop", 32'(mv[0]), 0);
    chk("basic_rdy_back", 32'(rdy[0]), 1);

    vld[1] = 1'b1;
    din[1] = pk(300, -5);
    srdy[1] = 1'b1;
    mrdy[1] = 1'b1;
    tick();
    chk("sat_sd", 32'(sd[1]), 32'h7F00);
    chk("sat_md", 32'(md[1]), 0);
    din[1] = pk(127, 128);
    #1;
    chk("sat_rdy_burst", 32'(rdy[1]), 1);
    tick();
    vld[1] = 1'b0;
    chk("edge_sv", 32'(sv[1]), 1);
    chk("edge_sd", 32'(sd[1]), 32'h7F7F);
    chk("edge_md", 32'(md[1]), 2);
    tick();
    chk("edge_sv_drop", 32'(sv[1]), 0);

    drain_test(1);
    drain_test(0);

    srdy[1] = 1'b1;
    mrdy[1] = 1'b1;
    vld[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din[1] = pk(k, k);
      #1;
      chk($sformatf("strm%0d_rdy", k), 32'(rdy[1]), 1);
      tick();
      chk($sformatf("strm%0d_sv", k), 32'(sv[1]), 1);
      chk($sformatf("strm%0d_sd", k), 32'(sd[1]), 32'({8'(k), 8'(k)}));
      chk($sformatf("strm%0d_md", k), 32'(md[1]), 3);
    end
    vld[1] = 1'b0;
    tick();
    chk("strm_sv_drop", 32'(sv[1]), 0);

    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b1;
      din[i] = pk(9, 9);
      srdy[i] = 1'b0;
      mrdy[i] = 1'b0;
    end
    tick();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    chk("pre_rst0_sv", 32'(sv[0]), 1);
    chk("pre_rst1_sv", 32'(sv[1]), 1);
    #2;
    iRST = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst%0d_sv", i), 32'(sv[i]), 0);
      chk($sformatf("arst%0d_sd", i), 32'(sd[i]), 0);
      chk($sformatf("arst%0d_mv", i), 32'(mv[i]), 0);
      chk($sformatf("arst%0d_md", i), 32'(md[i]), 0);
      chk($sformatf("arst%0d_rdy", i), 32'(rdy[i]), 0);
    end
    tick();
    chk("arst_hold_rdy", 32'(rdy[1]), 0);
    iRST = 1'b0;
    #1;
    chk("arst_rel0_rdy", 32'(rdy[0]), 1);
    chk("arst_rel1_rdy", 32'(rdy[1]), 1);
    chk("arst_rel1_sv", 32'(sv[1]), 0);

    srdy[1] = 1'b1;
    mrdy[1] = 1'b1;
    vld[1] = 1'b1;
    din[1] = pk(5, -1);
    tick();
    vld[1] = 1'b0;
    chk("post_sv", 32'(sv[1]), 1);
    chk("post_sd", 32'(sd[1]), 32'h0500);
    chk("post_md", 32'(md[1]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/activate.md
# activate

Per-layer activation stage placed downstream of the multiply-accumulate block. It accepts one packet of NC signed accumulator sums and applies a clipped ReLU that saturates to WF bits. It forks the result into two independent streams: the activated state vector for the next layer's state input, and a per-neuron derivative mask for the backward pass. Each output has its own one-entry register, so the two consumers drain independently.

## Interface
- NP, 3, number of inputs of the preceding layer; sets accumulator width WA = $clog2(NP)+WF
- NC, 2, number of neurons (lanes) per packet
- WF, 8, fixed-point width of state values
- BURST, "yes", "yes": input may be accepted in the same cycle a full slot drains; "no": input accepted only when both slots are empty
- iCLK  in  1  clock; all state changes on the rising edge
- iRST  in  1  reset; one clock, reset asynchronous and active-high
- iValid_AM_Accum0  in  1  accumulator packet valid
- oReady_AM_Accum0  out  1  block can accept the accumulator packet
- iData_AM_Accum0  in  NC*WA  lane k at [k*WA+:WA], signed two's complement
- oValid_BM_State1  out  1  activated state packet valid
- iReady_BM_State1  in  1  state consumer ready
- oData_BM_State1  out  NC*WF  lane k at [k*WF+:WF], signed, range 0..2^(WF-1)-1
- oValid_BM_Mask  out  1  derivative mask valid
- iReady_BM_Mask  in  1  mask consumer ready
- oData_BM_Mask  out  NC  bit k = derivative of lane k

## Operation
- A transfer on any port occurs at a rising edge where valid and ready are both 1.
- Per lane, with x the signed WA-bit input and MAX = 2^(WF-1)-1:
  - x <= 0 -> state 0, mask 0
  - 0 < x <= MAX -> state x[WF-1:0], mask 1
  - x > MAX -> state MAX, mask 0
- The lane function is combinational; its result is captured into both slot registers on input acceptance.
- Two slots, S (state) and M (mask), each hold a full flag plus data.
- Slot free condition:
  - BURST="no": free = !full
  - BURST="yes": free = !full || iReady of that output, which gives a combinational path from iReady to oReady.
- oReady_AM_Accum0 = free_S && free_M. The input is never accepted into only one slot.
- On accept, both slots load and set full.
- Otherwise a slot whose output transfers clears full. Its data register holds its last value.
- oValid_BM_State1 = full_S and oValid_BM_Mask = full_M. Each output's data is stable while its valid is 1 and ready is 0.
- Simultaneous drain and accept on a slot in BURST="yes": the slot stays full and takes the new data.
- Reset, asynchronous at any time including mid-transfer:
  - full_S = full_M = 0; data registers 0.
  - oValid_BM_State1 = 0, oData_BM_State1 = 0, oValid_BM_Mask = 0, oData_BM_Mask = 0.
  - oReady_AM_Accum0 = 0 while iRST is 1.
  - A packet pending at reset is discarded.
  - oReady returns to 1 in the first cycle after iRST falls.

## Timing
- Latency: a packet accepted at edge t has both outputs valid in the cycle after t (one-cycle latency).
- Throughput:
  - BURST="yes" with both readies held high: one packet per cycle.
  - BURST="no": at most one packet every 2 cycles.
- Fork stall: if one output is held not-ready, its slot stays full and oReady_AM_Accum0 stays 0 (BURST="yes": until that ready rises). The other output drains once and then shows valid 0.
- No combinational path from iValid_AM_Accum0 or iData_AM_Accum0 to any output.

## Test plan
All scenarios use NP=3, NC=2, WF=8, WA=10.
- Basic, BURST="no": send lanes {1:100, 0:1} with both readies 1 -> one cycle later State1={100,1}, Mask=2'b11; both valids drop after transfer; oReady is 0 in the cycle with full slots.
- Saturation and negatives: send {1:300, 0:-5} -> State1={127,0}, Mask=2'b00. Send {1:127, 0:128} -> State1={127,127}, Mask=2'b10.
- Independent drain: iReady_BM_Mask=1, iReady_BM_State1=0 for 5 cycles -> Mask transfers once; State1 valid stays 1 with stable data {127,0}; oReady stays 0. Raising State1 ready drains it; oReady is 1 in that cycle (BURST="yes") or the next (BURST="no").
- Streaming, BURST="yes": 4 back-to-back packets {k,k} for k=1..4 with both readies 1 -> 4 consecutive output cycles with State1={k,k}, Mask=2'b11, and oReady constantly 1.
- Reset mid-operation: raise iRST asynchronously while both slots are full -> outputs are valid=0 and data=0 immediately, with no clock edge required; oReady=0 during reset and 1 in the first cycle after release; the next packet {5,-1} yields State1={5,0}, Mask=2'b10.
